// File: rtl/picomips_pkg.sv
// Shared picoMIPS types: opcodes, fetch FSM states
// and default instruction geometry.
package picomips_pkg;

    localparam int ISIZE  = 24;
    localparam int OPSIZE = 3;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ADD   = 3'd1,
        OP_ADDI  = 3'd2,
        OP_MUL   = 3'd3,
        OP_MULI  = 3'd4,
        OP_WAITH = 3'd5,
        OP_WAITL = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fc_state_t;

    function automatic logic is_wait_op(input opcode_t op);
        return (op == OP_WAITH) || (op == OP_WAITL);
    endfunction

    function automatic logic wait_met(input opcode_t op, input logic go);
        return ((op == OP_WAITH) && go) || ((op == OP_WAITL) && !go);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a debounce counter
// that only accepts levels stable for DEB cycles.
module sw_debounce #(
    parameter int DEB = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q
);

    localparam int CW = $clog2(DEB + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = d_async;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q = db_q;

endmodule

// File: rtl/fetch_ctrl.sv
// picoMIPS sequencing controller: decodes the current
// opcode into PC-increment and datapath strobes.
module fetch_ctrl
    import picomips_pkg::*;
#(
    parameter int Isize  = ISIZE,
    parameter int OPsize = OPSIZE,
    parameter int DEB    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] instr,
    input  logic             sw_go,
    output logic             PCincr,
    output logic             reg_we,
    output logic             imm_sel,
    output logic             alu_op,
    output logic             waiting,
    output logic             halted
);

    opcode_t   op;
    fc_state_t state_q, state_d;
    logic      go_db;
    logic      pc_s, we_s, imm_s, alu_s;
    logic      unused_operands;

    assign op = opcode_t'(instr[Isize-1 -: OPsize]);
    assign unused_operands = ^instr[Isize-OPsize-1:0];

    sw_debounce #(
        .DEB(DEB)
    ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .d_async(sw_go),
        .q      (go_db)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (op == OP_HALT) begin
                    state_d = HALT;
                end else if (is_wait_op(op) && !wait_met(op, go_db)) begin
                    state_d = WAIT;
                end
            end
            // a non-wait opcode here means corrupted memory: resume
            WAIT: begin
                if (!is_wait_op(op) || wait_met(op, go_db)) begin
                    state_d = RUN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_s  = 1'b0;
        we_s  = 1'b0;
        imm_s = 1'b0;
        alu_s = 1'b0;
        unique case (state_q)
            RUN: begin
                unique case (op)
                    OP_NOP: pc_s = 1'b1;
                    OP_ADD, OP_ADDI, OP_MUL, OP_MULI: begin
                        pc_s  = 1'b1;
                        we_s  = 1'b1;
                        imm_s = (op == OP_ADDI) || (op == OP_MULI);
                        alu_s = (op == OP_MUL) || (op == OP_MULI);
                    end
                    OP_WAITH, OP_WAITL: pc_s = wait_met(op, go_db);
                    default: pc_s = 1'b0;
                endcase
            end
            WAIT:    pc_s = wait_met(op, go_db);
            default: pc_s = 1'b0;
        endcase
    end

    assign PCincr  = pc_s  & ~reset;
    assign reg_we  = we_s  & ~reset;
    assign imm_sel = imm_s & ~reset;
    assign alu_op  = alu_s & ~reset;
    assign waiting = (state_q == WAIT) & ~reset;
    assign halted  = (state_q == HALT) & ~reset;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected
// strobes, a monitor pops and compares them.
module tb_fetch_ctrl;
    import picomips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] instr;
    logic        sw_go;
    logic        PCincr, reg_we, imm_sel, alu_op, waiting, halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [5:0] v;
        bit         ci;
        logic [2:0] cnt;
        logic       db;
    } exp_t;

    exp_t q[$];
    event sample_ev;

    fetch_ctrl #(.Isize(24), .OPsize(3), .DEB(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .instr  (instr),
        .sw_go  (sw_go),
        .PCincr (PCincr),
        .reg_we (reg_we),
        .imm_sel(imm_sel),
        .alu_op (alu_op),
        .waiting(waiting),
        .halted (halted)
    );

    always #5 clk = ~clk;

    function automatic void push(input string nm, input logic [5:0] v,
                                 input bit ci = 1'b0,
                                 input logic [2:0] c = 3'd0,
                                 input logic d = 1'b0);
        exp_t e;
        e.nm  = nm;
        e.v   = v;
        e.ci  = ci;
        e.cnt = c;
        e.db  = d;
        q.push_back(e);
    endfunction

    // monitor: {PCincr,reg_we,imm_sel,alu_op,waiting,halted}
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() != 0) begin
                e   = q.pop_front();
                got = {PCincr, reg_we, imm_sel, alu_op, waiting, halted};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s: outputs got %b want %b", e.nm, got, e.v);
                end
                if (e.ci) begin
                    checks++;
                    if (dut.u_deb.cnt_q !== e.cnt || dut.u_deb.db_q !== e.db) begin
                        errors++;
                        $display("FAIL %s: cnt/go_db got %0d/%b want %0d/%b",
                                 e.nm, dut.u_deb.cnt_q, dut.u_deb.db_q, e.cnt, e.db);
                    end
                end
            end
        end
    end

    task automatic set_in(input opcode_t op, input logic sw);
        instr = {op, 21'h15A5A};
        sw_go = sw;
    endtask

    task automatic step(input opcode_t op, input logic sw,
                        input string nm, input logic [5:0] v);
        @(posedge clk);
        #1;
        set_in(op, sw);
        push(nm, v);
    endtask

    initial begin
        reset = 1'b1;
        set_in(OP_ADD, 1'b0);
        #3;
        push("reset_hold", 6'b000000, 1'b1, 3'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push("first_add", 6'b110000);

        step(OP_ADDI, 1'b0, "addi", 6'b111000);
        step(OP_MUL,  1'b0, "mul",  6'b110100);
        step(OP_MULI, 1'b0, "muli", 6'b111100);
        step(OP_NOP,  1'b0, "nop",  6'b100000);
        step(OP_ADD,  1'b0, "add",  6'b110000);
        step(OP_WAITL, 1'b0, "waitl_pass", 6'b100000);

        // WAITH blocked, then sw_go rises: six edges to release
        step(OP_WAITH, 1'b0, "waith_enter", 6'b000000);
        step(OP_WAITH, 1'b1, "waith_rise", 6'b000010);
        for (int i = 1; i <= 5; i++) step(OP_WAITH, 1'b1, "waith_hold", 6'b000010);
        step(OP_WAITH, 1'b1, "waith_exit", 6'b100010);
        step(OP_NOP, 1'b1, "run_after_waith", 6'b100000);

        // WAITL blocked until go_db falls
        step(OP_WAITL, 1'b0, "waitl_enter", 6'b000000);
        for (int i = 1; i <= 5; i++) step(OP_WAITL, 1'b0, "waitl_hold", 6'b000010);
        step(OP_WAITL, 1'b0, "waitl_exit", 6'b100010);
        step(OP_NOP, 1'b0, "run_after_waitl", 6'b100000);

        // three-cycle glitch must be rejected
        step(OP_WAITH, 1'b0, "glitch_enter", 6'b000000);
        for (int i = 0; i < 3; i++) step(OP_WAITH, 1'b1, "glitch_hi", 6'b000010);
        for (int i = 0; i < 8; i++) step(OP_WAITH, 1'b0, "glitch_lo", 6'b000010);
        step(OP_WAITH, 1'b0, "glitch_db", 6'b000010);
        q[q.size()-1].ci = 1'b1;

        // corrupted instruction in WAIT: back to RUN, no increment
        step(OP_NOP, 1'b0, "wait_corrupt", 6'b000010);
        step(OP_WAITL, 1'b0, "waitl_immediate", 6'b100000);

        // reset mid-WAIT with cnt=2
        step(OP_WAITH, 1'b0, "rst_wait_enter", 6'b000000);
        step(OP_WAITH, 1'b1, "rst_wait_rise", 6'b000010);
        for (int i = 0; i < 3; i++) step(OP_WAITH, 1'b1, "rst_wait_hold", 6'b000010);
        step(OP_WAITH, 1'b1, "rst_wait_cnt2", 6'b000010);
        q[q.size()-1].ci  = 1'b1;
        q[q.size()-1].cnt = 3'd2;
        @(negedge clk);
        #1;
        reset = 1'b1;
        sw_go = 1'b0;
        #1;
        push("rst_mid_wait", 6'b000000, 1'b1, 3'd0, 1'b0);
        -> sample_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(OP_HALT, 1'b0);
        push("halt_decode", 6'b000000);

        for (int i = 0; i < 100; i++)
            step(OP_HALT, logic'((i % 7) < 3), "halt_hold", 6'b000001);
        @(negedge clk);
        #1;
        reset = 1'b1;
        sw_go = 1'b0;
        #1;
        push("rst_halt", 6'b000000, 1'b1, 3'd0, 1'b0);
        -> sample_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(OP_ADD, 1'b0);
        push("add_after_halt", 6'b110000);
        step(OP_MULI, 1'b0, "muli_after_halt", 6'b111100);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending got, 0 want", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the picoMIPS core, directly upstream of the program counter. Each cycle it decodes the opcode of the instruction that program memory returns at the current PC and drives the PC's `PCincr` input, together with register-file and ALU strobes. It stalls the PC on handshake instructions until a debounced external switch (`sw_go`) reaches the required level, and freezes the PC permanently on HALT.

## Interface
- `Isize`, 24, instruction width in bits.
- `OPsize`, 3, opcode width; the opcode is `instr[Isize-1 -: OPsize]`.
- `DEB`, 4, debounce length in cycles; must be ≥1.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instr` in Isize: instruction word from program memory at the current PC.
- `sw_go` in 1: raw external handshake switch, asynchronous to `clk`.
- `PCincr` out 1: high means the PC increments this edge; low means it holds.
- `reg_we` out 1: register-file write enable.
- `imm_sel` out 1: ALU operand B is the immediate (1) or a register (0).
- `alu_op` out 1: 0 selects add; 1 selects multiply.
- `waiting` out 1: high while in state WAIT.
- `halted` out 1: high while in state HALT.

## Operation
- Opcodes:
  - NOP = 0
  - ADD = 1
  - ADDI = 2
  - MUL = 3
  - MULI = 4
  - WAITH = 5: wait until go is high.
  - WAITL = 6: wait until go is low.
  - HALT = 7
- Synchroniser and debounce:
  - `sw_go` passes through 2 flops to give `go_sync`.
  - Counter `cnt` has width `$clog2(DEB+1)`.
  - If `go_sync == go_db`, then `cnt` ← 0.
  - Otherwise, if `cnt == DEB-1`, then `go_db` ← `go_sync` and `cnt` ← 0.
  - Otherwise `cnt` increments.
  - A glitch shorter than DEB cycles at `go_sync` never changes `go_db`.
- FSM states: RUN, WAIT, HALT.
- RUN:
  - ALU ops (opcodes 1–4): `PCincr`=1 and `reg_we`=1. `imm_sel`=1 for ADDI/MULI. `alu_op`=1 for MUL/MULI.
  - NOP: `PCincr`=1, `reg_we`=0.
  - WAITH/WAITL with condition already met (`go_db`=1 / `go_db`=0): `PCincr`=1, stay in RUN.
  - WAITH/WAITL with condition not met: `PCincr`=0, go to WAIT.
  - HALT: `PCincr`=0, go to HALT.
- WAIT:
  - `PCincr`=0 and `reg_we`=0 while the condition for the held instruction is false.
  - The opcode is re-decoded from `instr` each cycle; the PC is frozen, so `instr` is stable.
  - The first cycle the condition is true: `PCincr`=1, go to RUN.
  - If `instr` is not WAITH/WAITL while in WAIT (corrupted memory), go to RUN with `PCincr`=0.
- HALT: all strobes 0, `halted`=1. Only `reset` exits HALT.
- Strobe outputs are combinational from state, `instr` and `go_db`. `waiting` and `halted` decode the state register.

## Timing
- While `reset` is asserted, and immediately on assertion:
  - state=RUN, sync flops=0, `go_db`=0, `cnt`=0.
  - All outputs forced to 0, including `PCincr`.
- After reset release, the first rising edge executes the instruction at PC 0.
- Throughput: 1 instruction per clock in RUN. Decode to `PCincr` has zero-cycle latency (same cycle).
- `sw_go` edge to `go_db` change: DEB+2 rising edges, provided `sw_go` stays stable.
- WAIT exit: `PCincr`=1 in the same cycle `go_db` reaches the required level. The PC advances on that edge.
- Reset asserted mid-WAIT or in HALT: the state returns to RUN asynchronously, and the debounce state is cleared.
- `go_db` toggling in the same cycle a WAIT instruction is first decoded: the decision uses the `go_db` value held in the register during that cycle.

## Structure
- Package `picomips_pkg` holds:
  - the opcode enum `opcode_t`
  - the FSM enum `fc_state_t`
  - default `Isize`/`OPsize` constants, shared with the decoder and the PC.
- One sub-module, `sw_debounce` (parameter DEB; ports `clk`, `reset`, `d_async`, `q`), holds the synchroniser and debounce counter. `fetch_ctrl` holds the FSM and decode.

## Test plan
- Reset held with opcode ADD on `instr` → all outputs 0. After release: `PCincr`=1, `reg_we`=1, `imm_sel`=0, `alu_op`=0 on the first edge.
- Stream ADDI, MUL, MULI, NOP → strobes per cycle:
  - ADDI: `imm_sel`=1, `alu_op`=0.
  - MUL: `imm_sel`=0, `alu_op`=1.
  - MULI: `imm_sel`=1, `alu_op`=1.
  - NOP: `reg_we`=0.
  - `PCincr`=1 throughout.
- WAITH with `sw_go`=0, then raise `sw_go` (DEB=4) → `waiting`=1 and `PCincr`=0. `PCincr`=1 on exactly the 6th edge after the rise, then RUN.
- In WAIT, a 3-cycle `sw_go` pulse (DEB=4) → `go_db` stays 0 and the PC never increments. Then WAITL with `go_db`=0 → passes immediately with `PCincr`=1.
- HALT → `halted`=1 and `PCincr`=0 for 100 cycles regardless of `sw_go`. Reset → `halted`=0 asynchronously.
- Assert `reset` mid-WAIT with `cnt`=2 → state RUN, `cnt`=0, `go_db`=0, `waiting`=0 before the next edge.
